// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter: frame-granular round-robin arbiter feeding one AXI-stream MAC TX port
module eth_tx_frame_arbiter #(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_BEATS = 1518,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [7:0]       s0_tdata,
  input  logic             s0_tvalid,
  input  logic             s0_tlast,
  output logic             s0_tready,
  input  logic [7:0]       s1_tdata,
  input  logic             s1_tvalid,
  input  logic             s1_tlast,
  output logic             s1_tready,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic             grant,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt0,
  output logic [CNT_W-1:0] frame_cnt1,
  output logic             trunc_err
);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int GW = IFG_CYCLES > 1 ? $clog2(IFG_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, PASS, DRAIN, GAP} state_t;
  localparam state_t END_ST = IFG_CYCLES == 0 ? IDLE : GAP;
  state_t state;
  logic last_served;
  logic [BW-1:0] beat_cnt;
  logic [GW-1:0] gap_cnt;
  logic sel_valid;
  logic sel_last;
  logic forced;
  // Steer the granted source to the MAC; the sink side is silent outside PASS
  always_comb begin
    sel_valid = grant ? s1_tvalid : s0_tvalid;
    sel_last = grant ? s1_tlast : s0_tlast;
    forced = beat_cnt == BW'(MAX_BEATS - 1);
    m_tvalid = state == PASS && sel_valid;
    m_tdata = state == PASS ? (grant ? s1_tdata : s0_tdata) : 8'd0;
    m_tlast = state == PASS && (sel_last || forced);
    s0_tready = !grant && (state == DRAIN || (state == PASS && m_tready));
    s1_tready = grant && (state == DRAIN || (state == PASS && m_tready));
    busy = state != IDLE;
  end
  // Arbitration, per-frame beat tracking, truncation drain and inter-frame gap
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 1'b0;
      last_served <= 1'b1;
      beat_cnt <= '0;
      gap_cnt <= '0;
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
      trunc_err <= 1'b0;
    end else begin
      trunc_err <= 1'b0;
      case (state)
        IDLE: if (enable && (s0_tvalid || s1_tvalid)) begin
          grant <= s0_tvalid && s1_tvalid ? !last_served : s1_tvalid;
          beat_cnt <= '0;
          state <= PASS;
        end
        PASS: if (m_tvalid && m_tready) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (sel_last || forced) begin
            if (!grant && frame_cnt0 != '1) frame_cnt0 <= frame_cnt0 + 1'b1;
            if (grant && frame_cnt1 != '1) frame_cnt1 <= frame_cnt1 + 1'b1;
            last_served <= grant;
            trunc_err <= !sel_last;
            gap_cnt <= '0;
            state <= sel_last ? END_ST : DRAIN;
          end
        end
        DRAIN: if (sel_valid && sel_last) begin
          gap_cnt <= '0;
          state <= END_ST;
        end
        GAP: if (gap_cnt == GW'(IFG_CYCLES - 1)) state <= IDLE;
             else gap_cnt <= gap_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
